// File: rtl/sevenseg_pkg.sv
// Shared constants for the 4-digit seven-segment scanner: digit count,
// scan FSM encoding, hex-to-segment table and the display content record.
package sevenseg_pkg;

   localparam int unsigned NUM_DIGITS = 4;

   typedef enum logic {
      GAP_S   = 1'b0,
      DRIVE_S = 1'b1
   } state_e;

   // Segment order {G,F,E,D,C,B,A}, active-high.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] digits;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   blank;
   } disp_t;

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to seven-segment pattern (active-high).
module hex7_decode
   import sevenseg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner with dark gaps between slots and
// double-buffered content that only swaps at the frame boundary.
module sevenseg_scan_ctrl
   import sevenseg_pkg::*;
#(
   parameter int unsigned DIV     = 12500,
   parameter int unsigned GAP     = 64,
   parameter bit          DIG_INV = 1'b1,
   parameter bit          SEG_INV = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [15:0] upd_digits,
   input  logic [3:0]  upd_dp,
   input  logic [3:0]  upd_blank,
   output logic [7:0]  seg,
   output logic [3:0]  dig_en,
   output logic        frame_done
);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   disp_t       act_q, act_d, shd_q, shd_d;
   logic        pend_q, pend_d;
   logic        rdy_q;
   logic        fdone_q;
   logic [7:0]  seg_q, seg_d;
   logic [3:0]  dig_q, dig_d;
   logic [3:0]  nib;
   logic [6:0]  dec_seg;
   logic        boundary, take;

   assign take      = upd_valid && rdy_q;
   assign upd_ready = rdy_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 16'd1;
      idx_d    = idx_q;
      boundary = 1'b0;
      case (state_q)
         GAP_S: begin
            if (cnt_q == 16'(GAP - 1)) begin
               state_d = DRIVE_S;
               cnt_d   = '0;
            end
         end
         DRIVE_S: begin
            if (cnt_q == 16'(DIV - 1)) begin
               state_d  = GAP_S;
               cnt_d    = '0;
               idx_d    = idx_q + 2'd1;
               boundary = (idx_q == 2'(NUM_DIGITS - 1));
            end
         end
      endcase
   end

   // Shadow is full whenever pending is set, so a swap and a capture never coincide.
   always_comb begin
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      if (boundary && pend_q) begin
         act_d  = shd_q;
         pend_d = 1'b0;
      end else if (take) begin
         shd_d  = '{digits: upd_digits, dp: upd_dp, blank: upd_blank};
         pend_d = 1'b1;
      end
   end

   // Output registers are loaded from next-state so the pins line up with the FSM.
   assign nib = act_q.digits[{idx_d, 2'b00} +: 4];

   hex7_decode u_dec (
      .hex_i (nib),
      .seg_o (dec_seg)
   );

   always_comb begin
      seg_d = '0;
      dig_d = '0;
      if (state_d == DRIVE_S && !act_q.blank[idx_d]) begin
         seg_d = {act_q.dp[idx_d], dec_seg};
         dig_d = 4'b0001 << idx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= GAP_S;
         cnt_q   <= '0;
         idx_q   <= '0;
         act_q   <= '{digits: '0, dp: '0, blank: 4'hF};
         shd_q   <= '0;
         pend_q  <= 1'b0;
         rdy_q   <= 1'b0;
         fdone_q <= 1'b0;
         seg_q   <= '0;
         dig_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         act_q   <= act_d;
         shd_q   <= shd_d;
         pend_q  <= pend_d;
         rdy_q   <= !pend_d;
         fdone_q <= boundary;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
      end
   end

   assign seg        = seg_q ^ {8{SEG_INV}};
   assign dig_en     = dig_q ^ {4{DIG_INV}};
   assign frame_done = fdone_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench: a frame-position reference model pushes the expected pin
// state every cycle; a separate monitor pops and compares against the DUT.
module tb_sevenseg_scan_ctrl;

   localparam int DIV   = 4;
   localparam int GAP   = 1;
   localparam int SLOT  = DIV + GAP;
   localparam int FRAME = 4 * SLOT;

   localparam logic [6:0] HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef struct packed {
      int         t;
      logic [7:0] seg;
      logic [3:0] dig;
      logic       fd;
      logic       rdy;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        upd_valid = 1'b0;
   logic [15:0] upd_digits = '0;
   logic [3:0]  upd_dp = '0;
   logic [3:0]  upd_blank = '0;
   logic        upd_ready, frame_done;
   logic [7:0]  seg;
   logic [3:0]  dig_en;

   int   n_chk = 0;
   int   n_pass = 0;
   obs_t exp_q[$];
   obs_t m_e, a_e;

   // Reference model state: t counts cycles since the last reset edge.
   bit          m_ok = 1'b0;
   int          m_t = 0;
   bit          m_pend = 1'b0;
   logic [15:0] a_dig = '0, s_dig = '0;
   logic [3:0]  a_dp = '0, a_bl = 4'hF, s_dp = '0, s_bl = '0;

   always #5 clk = ~clk;

   sevenseg_scan_ctrl #(.DIV(DIV), .GAP(GAP), .DIG_INV(1'b1), .SEG_INV(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_digits (upd_digits),
      .upd_dp     (upd_dp),
      .upd_blank  (upd_blank),
      .seg        (seg),
      .dig_en     (dig_en),
      .frame_done (frame_done)
   );

   function automatic obs_t expect_now();
      obs_t e;
      int   p, s;
      p     = m_t % FRAME;
      s     = p / SLOT;
      e.t   = m_t;
      e.seg = 8'h00;
      e.dig = 4'hF;
      e.fd  = (m_t > 0) && (p == 0);
      e.rdy = (m_t > 0) && !m_pend;
      if ((p % SLOT) >= GAP && !a_bl[s]) begin
         e.dig = ~(4'(4'b0001 << s));
         e.seg = {a_dp[s], HEX[a_dig[4*s +: 4]]};
      end
      return e;
   endfunction

   initial forever begin
      @(negedge clk);
      if (m_ok) exp_q.push_back(expect_now());
      if (rst) begin
         m_ok = 1'b1; m_t = 0; m_pend = 1'b0;
         a_dig = '0; a_dp = '0; a_bl = 4'hF;
      end else if (m_ok) begin
         if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
            a_dig = s_dig; a_dp = s_dp; a_bl = s_bl; m_pend = 1'b0;
         end else if (upd_valid && m_t > 0 && !m_pend) begin
            s_dig = upd_digits; s_dp = upd_dp; s_bl = upd_blank; m_pend = 1'b1;
         end
         m_t++;
      end
   end

   initial forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
         m_e = exp_q.pop_front();
         a_e = '{t: m_e.t, seg: seg, dig: dig_en, fd: frame_done, rdy: upd_ready};
         n_chk++;
         if (a_e === m_e) n_pass++;
         else $display("FAIL pins t=%0d got seg=%h dig=%b fd=%b rdy=%b want seg=%h dig=%b fd=%b rdy=%b",
                       m_e.t, a_e.seg, a_e.dig, a_e.fd, a_e.rdy, m_e.seg, m_e.dig, m_e.fd, m_e.rdy);
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_t(input int tgt);
      int k;
      k = 0;
      while (m_t != tgt && k < 300) begin
         step();
         k++;
      end
      if (m_t != tgt) begin
         n_chk++;
         $display("FAIL wait_t got t=%0d want t=%0d", m_t, tgt);
      end
   endtask

   task automatic offer(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
      upd_valid  = 1'b1;
      upd_digits = d;
      upd_dp     = dp;
      upd_blank  = bl;
      step();
      upd_valid  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      wait_t(1);
      offer(16'h4321, 4'h0, 4'h0);            // shown from the second frame
      wait_t(25);
      offer(16'h8A01, 4'b0001, 4'b0100);      // digit 2 dark, digit 0 with DP
      offer(16'hFFFF, 4'hF, 4'h0);            // pending: must be ignored
      wait_t(FRAME*3 - 1);
      offer(16'h5678, 4'h0, 4'h0);            // on the boundary clock
      wait_t(FRAME*3 + 2*SLOT + 2);
      rst = 1'b1;                             // mid digit-2 slot, shadow pending
      step();
      rst = 1'b0;
      step(2*FRAME);
      for (int i = 0; i < 800; i++) begin
         upd_valid  = ($urandom_range(0, 3) == 0);
         upd_digits = 16'($urandom);
         upd_dp     = 4'($urandom);
         upd_blank  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         rst        = ($urandom_range(0, 249) == 0);
         step();
      end
      upd_valid = 1'b0;
      rst       = 1'b0;
      step(3);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
